// File: rtl/cpu_pkg.sv
// Shared types and helpers for the fetch-side next-PC logic.
// Holds the redirect-buffer state encoding and the STEP alignment mask.
package cpu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } pcState_t;

  // STEP must be a power of two; the mask clears the low log2(STEP) bits.
  function automatic logic [63:0] alignMask(input int unsigned step);
    return ~(64'(step) - 64'd1);
  endfunction

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_select.sv
// Fixed-priority pick among redirect sources, highest index wins.
// Purely combinational, no handshake.
module prio_select
  import cpu_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = idxWidth(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]       valid,
  input  logic [NUM_SRC*WIDTH-1:0] target,
  output logic                     anyValid,
  output logic [IDX_W-1:0]         winIdx,
  output logic [WIDTH-1:0]         winTarget
);

  // Ascending scan: later (higher-index) hits overwrite earlier ones.
  always_comb begin
    anyValid  = 1'b0;
    winIdx    = '0;
    winTarget = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (valid[i]) begin
        anyValid  = 1'b1;
        winIdx    = IDX_W'(i);
        winTarget = target[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Program counter with prioritized redirects; one-cycle update latency.
// A stall holds PC and buffers the strongest redirect until the stall lifts.
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter int                WIDTH        = 32,
  parameter int                NUM_SRC      = 4,
  parameter int                STEP         = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic [NUM_SRC-1:0]       redirectValid,
  input  logic [NUM_SRC*WIDTH-1:0] redirectTarget,
  input  logic                     errClear,
  output logic [WIDTH-1:0]         PC,
  output logic [WIDTH-1:0]         pcPlusStep,
  output logic                     redirected,
  output logic                     pendingValid,
  output logic                     alignErr
);

  localparam int               IDX_W      = idxWidth(NUM_SRC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(alignMask(STEP));

  pcState_t         state;
  logic [IDX_W-1:0] bufIdx;
  logic [WIDTH-1:0] bufTarget;

  logic             curValid;
  logic [IDX_W-1:0] curIdx;
  logic [WIDTH-1:0] curTarget;

  logic             takeCur;
  logic             selValid;
  logic [IDX_W-1:0] selIdx;
  logic [WIDTH-1:0] selTarget;
  logic             misaligned;

  prio_select #(
    .NUM_SRC (NUM_SRC),
    .WIDTH   (WIDTH),
    .IDX_W   (IDX_W)
  ) u_prio (
    .valid     (redirectValid),
    .target    (redirectTarget),
    .anyValid  (curValid),
    .winIdx    (curIdx),
    .winTarget (curTarget)
  );

  assign pcPlusStep   = PC + WIDTH'(STEP);
  assign pendingValid = (state == HELD);

  // Equal index favours the live request so a re-issued redirect refreshes the target.
  always_comb begin
    takeCur    = curValid && ((state == RUN) || (curIdx >= bufIdx));
    selValid   = takeCur || (state == HELD);
    selIdx     = takeCur ? curIdx : bufIdx;
    selTarget  = takeCur ? curTarget : bufTarget;
    misaligned = |(selTarget & ~ALIGN_MASK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      bufIdx     <= '0;
      bufTarget  <= '0;
      PC         <= RESET_VECTOR;
      redirected <= 1'b0;
      alignErr   <= 1'b0;
    end else begin
      redirected <= 1'b0;
      if (stall) begin
        if (selValid) begin
          state     <= HELD;
          bufIdx    <= selIdx;
          bufTarget <= selTarget;
        end
      end else begin
        state     <= RUN;
        bufIdx    <= '0;
        bufTarget <= '0;
        if (selValid) begin
          PC         <= selTarget & ALIGN_MASK;
          redirected <= 1'b1;
        end else begin
          PC <= pcPlusStep;
        end
      end

      // Misalignment is flagged when the target is actually loaded, not when buffered.
      if (!stall && selValid && misaligned) begin
        alignErr <= 1'b1;
      end else if (errClear) begin
        alignErr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit with a cycle-level reference model.
// Model outputs are checked every falling edge; scenario steps pin literal values.
module tb_next_pc_unit;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 4;
  localparam int STEP    = 4;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     stall;
  logic                     errClear;
  logic [NUM_SRC-1:0]       redirectValid;
  logic [NUM_SRC*WIDTH-1:0] redirectTarget;
  logic [WIDTH-1:0]         tgt [NUM_SRC];

  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] pcPlusStep;
  logic             redirected;
  logic             pendingValid;
  logic             alignErr;

  assign redirectTarget = {tgt[3], tgt[2], tgt[1], tgt[0]};

  always #5 clk = ~clk;

  next_pc_unit #(
    .WIDTH        (WIDTH),
    .NUM_SRC      (NUM_SRC),
    .STEP         (STEP),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .errClear       (errClear),
    .PC             (PC),
    .pcPlusStep     (pcPlusStep),
    .redirected     (redirected),
    .pendingValid   (pendingValid),
    .alignErr       (alignErr)
  );

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending redirect is just an index (-1 = none) and a target.
  logic [31:0] mPc;
  bit          mHeld;
  int          mBufIdx;
  logic [31:0] mBufTgt;
  bit          mRedir;
  bit          mErr;
  int          curIdx;
  int          useIdx;
  logic [31:0] useTgt;

  function automatic int topIdx(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always_comb begin
    curIdx = topIdx(redirectValid);
    useIdx = -1;
    useTgt = 32'h0;
    if (mHeld && (curIdx < mBufIdx)) begin
      useIdx = mBufIdx;
      useTgt = mBufTgt;
    end else if (curIdx >= 0) begin
      useIdx = curIdx;
      useTgt = tgt[curIdx[1:0]];
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mPc     <= 32'h0;
      mHeld   <= 1'b0;
      mBufIdx <= -1;
      mBufTgt <= 32'h0;
      mRedir  <= 1'b0;
      mErr    <= 1'b0;
    end else if (stall) begin
      if (useIdx >= 0) begin
        mHeld   <= 1'b1;
        mBufIdx <= useIdx;
        mBufTgt <= useTgt;
      end
      mRedir <= 1'b0;
      if (errClear) mErr <= 1'b0;
    end else begin
      mHeld   <= 1'b0;
      mBufIdx <= -1;
      if (useIdx >= 0) begin
        mPc    <= useTgt - (useTgt % 32'(STEP));
        mRedir <= 1'b1;
        if ((useTgt % 32'(STEP)) != 0) mErr <= 1'b1;
        else if (errClear)             mErr <= 1'b0;
      end else begin
        mPc    <= mPc + 32'(STEP);
        mRedir <= 1'b0;
        if (errClear) mErr <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      cmp("model.PC",           PC,                  mPc);
      cmp("model.pcPlusStep",   pcPlusStep,          mPc + 32'(STEP));
      cmp("model.redirected",   32'(redirected),     32'(mRedir));
      cmp("model.pendingValid", 32'(pendingValid),   32'(mHeld));
      cmp("model.alignErr",     32'(alignErr),       32'(mErr));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset_n       = 1'b1;
    stall         = 1'b0;
    errClear      = 1'b0;
    redirectValid = '0;
    for (int i = 0; i < NUM_SRC; i++) tgt[i] = 32'h0;
    #2 reset_n = 1'b0;
    tick();
    cmp("rst.PC",         PC,                 32'h0);
    cmp("rst.pending",    32'(pendingValid),  32'h0);
    cmp("rst.redirected", 32'(redirected),    32'h0);
    cmp("rst.alignErr",   32'(alignErr),      32'h0);
    reset_n = 1'b1;
    checkEn = 1'b1;

    tick(); cmp("seq.PC1", PC, 32'h4);
    tick(); cmp("seq.PC2", PC, 32'h8);
    tick(); cmp("seq.PC3", PC, 32'hC);

    tgt[1] = 32'h100; tgt[2] = 32'h200; redirectValid = 4'b0110;
    tick(); cmp("prio.PC", PC, 32'h200); cmp("prio.redir", 32'(redirected), 32'h1);
    redirectValid = 4'b0000;
    tick(); cmp("prio.redirOff", 32'(redirected), 32'h0); cmp("prio.PCnext", PC, 32'h204);

    stall = 1'b1;
    tick(); cmp("stallHold.PC", PC, 32'h204); cmp("stallHold.pending", 32'(pendingValid), 32'h0);

    redirectValid = 4'b0010;
    tick(); cmp("held1.PC", PC, 32'h204); cmp("held1.pending", 32'(pendingValid), 32'h1);
    tgt[3] = 32'h300; redirectValid = 4'b1000;
    tick(); cmp("held2.PC", PC, 32'h204); cmp("held2.pending", 32'(pendingValid), 32'h1);
    stall = 1'b0; redirectValid = 4'b0000;
    tick(); cmp("held.release.PC", PC, 32'h300); cmp("held.release.pending", 32'(pendingValid), 32'h0);

    stall = 1'b1; redirectValid = 4'b0100;
    tick();
    redirectValid = 4'b0010;
    tick(); cmp("lowIgnored.pending", 32'(pendingValid), 32'h1);
    stall = 1'b0; redirectValid = 4'b0000;
    tick(); cmp("lowIgnored.PC", PC, 32'h200);

    stall = 1'b1; redirectValid = 4'b0100;
    tick();
    tgt[2] = 32'h240; stall = 1'b0;
    tick(); cmp("tieCurrent.PC", PC, 32'h240);
    redirectValid = 4'b0000; tgt[2] = 32'h200;

    tgt[0] = 32'h102; redirectValid = 4'b0001;
    tick(); cmp("align.PC", PC, 32'h100); cmp("align.err", 32'(alignErr), 32'h1);
    redirectValid = 4'b0000;
    tick(); cmp("align.sticky", 32'(alignErr), 32'h1); cmp("align.PCnext", PC, 32'h104);
    errClear = 1'b1;
    tick(); cmp("align.clear", 32'(alignErr), 32'h0);
    redirectValid = 4'b0001;
    tick(); cmp("align.setWins", 32'(alignErr), 32'h1);
    redirectValid = 4'b0000;
    tick(); cmp("align.clear2", 32'(alignErr), 32'h0);
    errClear = 1'b0;

    tgt[0] = 32'hFFFF_FFFC; redirectValid = 4'b0001;
    tick(); cmp("wrap.PC", PC, 32'hFFFF_FFFC); cmp("wrap.plusStep", pcPlusStep, 32'h0);
    redirectValid = 4'b0000;
    tick(); cmp("wrap.PCnext", PC, 32'h0);

    stall = 1'b1; redirectValid = 4'b1000;
    tick(); cmp("midStall.pending", 32'(pendingValid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    cmp("asyncRst.PC",      PC,                32'h0);
    cmp("asyncRst.pending", 32'(pendingValid), 32'h0);
    tick();
    stall = 1'b0; redirectValid = 4'b0000; reset_n = 1'b1;
    tick(); cmp("postRst.PC1", PC, 32'h4); cmp("postRst.pending", 32'(pendingValid), 32'h0);
    tick(); cmp("postRst.PC2", PC, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: PC and target width in bits.
REQ-002 The block SHALL take parameter NUM_SRC, default 4: number of redirect sources, minimum 1.
REQ-003 The block SHALL take parameter STEP, default 4: sequential increment.
REQ-004 The block SHALL take parameter RESET_VECTOR, default 0: PC value after reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port stall, input, 1 bit: hold PC this cycle.
REQ-008 The block SHALL have port redirectValid, input, NUM_SRC bits: per-source redirect request; higher index means higher priority.
REQ-009 The block SHALL have port redirectTarget, input, NUM_SRC*WIDTH bits: flattened targets; source i occupies bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port errClear, input, 1 bit: clears alignErr.
REQ-011 The block SHALL have port PC, output, WIDTH bits: current program counter.
REQ-012 The block SHALL have port pcPlusStep, output, WIDTH bits: PC+STEP, combinational from PC.
REQ-013 The block SHALL have port redirected, output, 1 bit: a one-cycle pulse when PC was loaded from a redirect target.
REQ-014 The block SHALL have port pendingValid, output, 1 bit: a redirect is buffered during a stall.
REQ-015 The block SHALL have port alignErr, output, 1 bit: sticky flag for a misaligned target.

Function
REQ-016 The block SHALL implement two states: RUN (no buffered redirect) and HELD (redirect buffered).
REQ-017 In RUN with stall=0, the next PC SHALL be the target of the highest-index asserted redirectValid bit, or PC+STEP if none is asserted.
REQ-018 In RUN with stall=1 and no redirect, PC SHALL hold.
REQ-019 In RUN with stall=1 and a redirect asserted, PC SHALL hold, the winning target and its index SHALL be latched, and the state SHALL go to HELD.
REQ-020 In HELD with stall=1, a new redirect whose index is greater than or equal to the buffered index SHALL overwrite the buffer, and a lower-index redirect SHALL be ignored.
REQ-021 In HELD with stall=0, the next PC SHALL be the winner between the buffered redirect and current-cycle redirects by the same priority rule (ties go to current), and the state SHALL return to RUN.
REQ-022 PC update latency SHALL be one clock: inputs sampled at edge N are visible on PC after edge N.
REQ-023 redirected SHALL be 1 for exactly the cycle after any edge that loaded a redirect target.
REQ-024 A winning target with (target mod STEP) != 0 SHALL still be loaded, with its low log2(STEP) bits forced to 0, and alignErr SHALL be set.
REQ-025 alignErr SHALL stay 1 until an edge with errClear=1; if a new misalignment and errClear occur in the same cycle, set SHALL win.
REQ-026 PC+STEP SHALL wrap modulo 2^WIDTH without any flag.
REQ-027 pendingValid SHALL be 1 exactly when the state is HELD.

Reset
REQ-028 While reset_n=0, and independent of clk, the block SHALL drive PC=RESET_VECTOR, state=RUN, the buffer cleared, redirected=0 and alignErr=0.
REQ-029 Asserting reset mid-stall SHALL discard any buffered redirect.
REQ-030 After reset is released, the first edge SHALL advance normally per REQ-017.

Structure
REQ-031 The state encoding and the STEP alignment mask SHALL live in the shared package cpu_pkg.
REQ-032 The priority selection SHALL be a sub-module prio_select returning the winner index, a valid bit and the target.
REQ-033 No other sub-modules SHALL be used.

Verification
REQ-034 Reset release with no redirects and stall=0 for 3 cycles -> PC sequence 0x0, 0x4, 0x8, 0xC.
REQ-035 redirectValid=4'b0110 with targets 1=0x100 and 2=0x200 -> PC=0x200 and redirected=1 for one cycle.
REQ-036 stall=1 with source1=0x100, next cycle stall=1 with source3=0x300, then stall=0 -> PC holds and then becomes 0x300; pendingValid is 1 for 2 cycles.
REQ-037 stall=1 with source2=0x200, then source1=0x100 while still stalled, then release -> PC=0x200.
REQ-038 Target 0x102 -> PC=0x100 and alignErr=1 sticky; errClear pulse -> alignErr=0.
REQ-039 PC=0xFFFFFFFC, then advance -> PC=0x0; reset_n pulsed while HELD -> PC=RESET_VECTOR and pendingValid=0.
